// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the NS/SN/EW/WE light bus, flags the first encoding, sequencing,
// conflict, dwell or starvation violation and counts completed green phases.
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_RED    = 40,
    parameter int CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       CLEAR_N,
    input  logic [1:0] NS,
    input  logic [1:0] SN,
    input  logic [1:0] EW,
    input  logic [1:0] WE,
    input  logic       ack,
    output logic       armed,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [7:0] phase_count
);

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    localparam logic [CNT_W-1:0] MIN_G_C  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_R_C  = CNT_W'(MAX_RED);
    localparam logic [CNT_W-1:0] SAT_C    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam bit               STARVE_EN = (MAX_RED != 0);

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        ARMED = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [1:0]       cur_s   [4];
    logic [1:0]       prev_r  [4];
    logic [CNT_W-1:0] dwell_r [4];

    logic [3:0] ill_s;
    logic [3:0] nonred_s;
    logic [3:0] trn_s;
    logic [3:0] sg_s;
    logic [3:0] sy_s;
    logic [3:0] st_s;
    logic [3:0] ph_s;
    logic       conflict_s;
    logic       all_red_s;
    logic       viol_s;
    logic [2:0] vcode_s;
    logic [1:0] vdir_s;
    logic [7:0] ph_inc_s;

    logic       armed_r;
    logic       fault_r;
    logic [2:0] fault_code_r;
    logic [1:0] fault_dir_r;
    logic [7:0] phase_count_r;

    // Lowest-index set bit, giving NS > SN > EW > WE priority.
    function automatic logic [1:0] first_dir(input logic [3:0] v);
        logic [1:0] d;
        if (v[0]) begin
            d = 2'd0;
        end else if (v[1]) begin
            d = 2'd1;
        end else if (v[2]) begin
            d = 2'd2;
        end else begin
            d = 2'd3;
        end
        return d;
    endfunction

    assign cur_s[0] = NS;
    assign cur_s[1] = SN;
    assign cur_s[2] = EW;
    assign cur_s[3] = WE;

    // Per-direction violation and phase-completion flags against the previous sample.
    always_comb begin
        ill_s    = 4'b0000;
        nonred_s = 4'b0000;
        trn_s    = 4'b0000;
        sg_s     = 4'b0000;
        sy_s     = 4'b0000;
        st_s     = 4'b0000;
        ph_s     = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            ill_s[d]    = (cur_s[d] == ILL);
            nonred_s[d] = (cur_s[d] != RED);
            trn_s[d]    = ((prev_r[d] == GRN) && (cur_s[d] == RED)) ||
                          ((prev_r[d] == RED) && (cur_s[d] == YEL)) ||
                          ((prev_r[d] == YEL) && (cur_s[d] == GRN));
            sg_s[d]     = (prev_r[d] == GRN) && (cur_s[d] == YEL) && (dwell_r[d] < MIN_G_C);
            sy_s[d]     = (prev_r[d] == YEL) && (cur_s[d] == RED) && (dwell_r[d] < MIN_Y_C);
            st_s[d]     = STARVE_EN && (prev_r[d] == RED) && (cur_s[d] == RED) &&
                          (dwell_r[d] >= MAX_R_C);
            ph_s[d]     = (prev_r[d] == YEL) && (cur_s[d] == RED) && (dwell_r[d] >= MIN_Y_C);
        end
        conflict_s = (nonred_s[0] | nonred_s[1]) & (nonred_s[2] | nonred_s[3]);
        all_red_s  = (nonred_s == 4'b0000);
        ph_inc_s   = 8'(ph_s[0]) + 8'(ph_s[1]) + 8'(ph_s[2]) + 8'(ph_s[3]);
    end

    // Resolve simultaneous violations: lowest code first, then direction priority.
    always_comb begin
        viol_s  = 1'b1;
        vcode_s = 3'd0;
        vdir_s  = 2'd0;
        if (ill_s != 4'b0000) begin
            vcode_s = 3'd1;
            vdir_s  = first_dir(ill_s);
        end else if (conflict_s) begin
            vcode_s = 3'd2;
            vdir_s  = first_dir(nonred_s);
        end else if (trn_s != 4'b0000) begin
            vcode_s = 3'd3;
            vdir_s  = first_dir(trn_s);
        end else if (sg_s != 4'b0000) begin
            vcode_s = 3'd4;
            vdir_s  = first_dir(sg_s);
        end else if (sy_s != 4'b0000) begin
            vcode_s = 3'd5;
            vdir_s  = first_dir(sy_s);
        end else if (st_s != 4'b0000) begin
            vcode_s = 3'd6;
            vdir_s  = first_dir(st_s);
        end else begin
            viol_s  = 1'b0;
        end
    end

    // Next-state logic for the SYNC / ARMED / FAULT controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SYNC: begin
                if (all_red_s) begin
                    state_nx_s = ARMED;
                end else begin
                    state_nx_s = SYNC;
                end
            end
            ARMED: begin
                if (viol_s) begin
                    state_nx_s = FAULT;
                end else begin
                    state_nx_s = ARMED;
                end
            end
            FAULT: begin
                if (ack) begin
                    state_nx_s = SYNC;
                end else begin
                    state_nx_s = FAULT;
                end
            end
            default: begin
                state_nx_s = SYNC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_r <= SYNC;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Previous-sample and dwell tracking; arming restarts every dwell at one red cycle.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            for (int d = 0; d < 4; d++) begin
                prev_r[d]  <= RED;
                dwell_r[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                prev_r[d] <= cur_s[d];
                if ((state_r == SYNC) && all_red_s) begin
                    dwell_r[d] <= ONE_C;
                end else if (cur_s[d] != prev_r[d]) begin
                    dwell_r[d] <= ONE_C;
                end else if (dwell_r[d] != SAT_C) begin
                    dwell_r[d] <= dwell_r[d] + ONE_C;
                end
            end
        end
    end

    // Registered outputs: fault latch keeps the first violation until ack.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            armed_r       <= 1'b0;
            fault_r       <= 1'b0;
            fault_code_r  <= 3'd0;
            fault_dir_r   <= 2'd0;
            phase_count_r <= 8'd0;
        end else begin
            armed_r <= (state_nx_s == ARMED);
            case (state_r)
                ARMED: begin
                    if (viol_s) begin
                        fault_r      <= 1'b1;
                        fault_code_r <= vcode_s;
                        fault_dir_r  <= vdir_s;
                    end else begin
                        phase_count_r <= phase_count_r + ph_inc_s;
                    end
                end
                FAULT: begin
                    if (ack) begin
                        fault_r      <= 1'b0;
                        fault_code_r <= 3'd0;
                        fault_dir_r  <= 2'd0;
                    end
                end
                default: begin
                    fault_r <= fault_r;
                end
            endcase
        end
    end

    assign armed       = armed_r;
    assign fault       = fault_r;
    assign fault_code  = fault_code_r;
    assign fault_dir   = fault_dir_r;
    assign phase_count = phase_count_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: the driver pushes one expected
// output word per clock, the monitor pops it after the edge and compares.
module tb_traffic_light_monitor;

    logic       CLK;
    logic       CLEAR_N;
    logic [1:0] NS, SN, EW, WE;
    logic       ack;
    logic       armed, fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic [7:0] phase_count;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    int vectors;
    int miscompares;
    logic [7:0] exp_pc;

    logic        q_chk  [$];
    logic [14:0] q_val  [$];
    string       q_name [$];

    traffic_light_monitor dut (
        .CLK(CLK), .CLEAR_N(CLEAR_N),
        .NS(NS), .SN(SN), .EW(EW), .WE(WE),
        .ack(ack), .armed(armed), .fault(fault),
        .fault_code(fault_code), .fault_dir(fault_dir),
        .phase_count(phase_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [14:0] mk(input logic a, input logic f, input logic [2:0] c,
                                       input logic [1:0] d, input logic [7:0] pc);
        return {a, f, c, d, pc};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {armed, fault, fault_code, fault_dir, phase_count};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got armed=%0b fault=%0b code=%0d dir=%0d pc=%0d, expected armed=%0b fault=%0b code=%0d dir=%0d pc=%0d",
                     name, act[14], act[13], act[12:10], act[9:8], act[7:0],
                     exp[14], exp[13], exp[12:10], exp[9:8], exp[7:0]);
        end
    endtask

    // One clock of stimulus; the expected word applies after the next rising edge.
    task automatic step(input logic [1:0] ns, input logic [1:0] sn, input logic [1:0] ew,
                        input logic [1:0] we, input logic a, input logic chk,
                        input logic [14:0] exp, input string name);
        @(negedge CLK);
        NS = ns; SN = sn; EW = ew; WE = we; ack = a;
        q_chk.push_back(chk);
        q_val.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic red(input int n);
        for (int i = 0; i < n; i++) step(R, R, R, R, 1'b0, 1'b0, 15'd0, "");
    endtask

    task automatic one_dir(input int dir, input logic [1:0] c);
        logic [7:0] t;
        t = {c, 6'b000000};
        t = t >> (2 * dir);
        step(t[7:6], t[5:4], t[3:2], t[1:0], 1'b0, 1'b0, 15'd0, "");
    endtask

    // Legal phase on one direction: green 4, yellow 2, then red closes it.
    task automatic phase(input int dir, input string name);
        for (int i = 0; i < 4; i++) one_dir(dir, G);
        for (int i = 0; i < 2; i++) one_dir(dir, Y);
        exp_pc = exp_pc + 8'd1;
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, exp_pc), name);
    endtask

    task automatic ack_rearm(input string name);
        step(R, R, R, R, 1'b1, 1'b1, mk(1'b0, 1'b0, 3'd0, 2'd0, exp_pc), {name, "_ack"});
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, exp_pc), {name, "_rearm"});
    endtask

    // Monitor: pop one expected word per clock and compare the registered outputs.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (q_chk.size() > 0) begin
                logic        c;
                logic [14:0] v;
                string       n;
                c = q_chk.pop_front();
                v = q_val.pop_front();
                n = q_name.pop_front();
                if (c) check(n, v);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; exp_pc = 8'd0;
        CLEAR_N = 1'b0; NS = G; SN = R; EW = G; WE = X; ack = 1'b0;
        #3;
        check("reset_state", mk(1'b0, 1'b0, 3'd0, 2'd0, 8'd0));
        @(negedge CLK);
        NS = R; EW = R; WE = R;
        @(negedge CLK);
        CLEAR_N = 1'b1;
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, 8'd0), "arm");
        phase(0, "phase_ns");

        step(G, R, G, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd2, 2'd0, exp_pc), "conflict");
        ack_rearm("conflict");

        for (int i = 0; i < 4; i++) one_dir(1, G);
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd3, 2'd1, exp_pc), "grn_to_red");
        ack_rearm("trans");

        for (int i = 0; i < 4; i++) one_dir(2, G);
        step(R, R, R, X, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd1, 2'd3, exp_pc), "illegal_beats_trans");
        ack_rearm("illegal");

        for (int i = 0; i < 3; i++) one_dir(2, G);
        step(R, R, Y, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd4, 2'd2, exp_pc), "short_green");
        ack_rearm("sg");

        for (int i = 0; i < 4; i++) one_dir(3, G);
        one_dir(3, Y);
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd5, 2'd3, exp_pc), "short_yellow");
        step(X, R, G, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd5, 2'd3, exp_pc), "first_fault_kept");
        ack_rearm("sy");

        red(38);
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, exp_pc), "red_at_limit");
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b0, 1'b1, 3'd6, 2'd0, exp_pc), "starvation");
        ack_rearm("starve");

        for (int i = 0; i < 254; i++) phase(i % 4, "phase_run");
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, 8'd255), "pc_255");
        phase(2, "pc_wrap");
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, 8'd0), "pc_is_0");
        phase(3, "pc_after_wrap");

        one_dir(0, G);
        one_dir(0, G);
        @(negedge CLK);
        CLEAR_N = 1'b0;
        #1;
        check("clear_mid_green", mk(1'b0, 1'b0, 3'd0, 2'd0, 8'd0));
        NS = R;
        @(negedge CLK);
        CLEAR_N = 1'b1;
        exp_pc = 8'd0;
        step(R, R, R, R, 1'b0, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, 8'd0), "resync");
        phase(1, "phase_after_clear");

        repeat (3) @(posedge CLK);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Conflict/sequence monitor on the consuming end of the 4-signal traffic light controller's NS/SN/EW/WE light bus. It samples the four 2-bit light codes every CLK and checks legal encoding, legal colour sequencing, axis conflicts, minimum green/yellow dwell and red starvation. On the first violation it latches a fault code and the offending direction until acknowledged. It also counts completed green phases. It sits beside the controller for safety checking in hardware and as a self-checking bench component.

Parameters:
MIN_GREEN, 4, minimum consecutive sampled cycles of green per phase
MIN_YELLOW, 2, minimum consecutive sampled cycles of yellow per phase
MAX_RED, 40, maximum consecutive red cycles per direction; 0 disables the starvation check
CNT_W, 8, width of each per-direction dwell counter; counters saturate at 2^CNT_W-1

Ports:
CLK  in  1  system clock, rising edge
CLEAR_N  in  1  asynchronous active-low reset
NS  in  2  north-south light code
SN  in  2  south-north light code
EW  in  2  east-west light code
WE  in  2  west-east light code
ack  in  1  clears a latched fault; level sampled on CLK
armed  out  1  monitor synchronised and checking
fault  out  1  latched violation flag
fault_code  out  3  violation type; valid while fault=1
fault_dir  out  2  offending direction: 0=NS, 1=SN, 2=EW, 3=WE
phase_count  out  8  completed green->yellow->red phases over all directions; wraps 255->0

Behaviour:
- Light encoding: 00=red, 01=yellow, 10=green, 11=illegal.
- Reset (CLEAR_N=0, async): state=SYNC; armed=0, fault=0, fault_code=0, fault_dir=0, phase_count=0. All prev-code registers=red, all dwell counters=0.
- FSM states: SYNC, ARMED, FAULT.
- SYNC: leave to ARMED after the first edge at which all four inputs sample red. armed=1 from that edge. Dwell counters restart at 1 for red. No checks run in SYNC.
- ARMED: checks run on each edge against the previous sample per direction. Any violation moves to FAULT at that same edge: fault=1 and code/dir are registered there. One-cycle latency from the input violation to fault high.
- Fault codes, in priority order (lowest value wins when several occur together):
  - 1 = illegal code 11.
  - 2 = axis conflict: any of NS/SN non-red while any of EW/WE non-red. fault_dir = the lowest-index non-red direction.
  - 3 = illegal transition: green->red, red->yellow, yellow->green.
  - 4 = short green: green->yellow with green dwell < MIN_GREEN.
  - 5 = short yellow: yellow->red with yellow dwell < MIN_YELLOW.
  - 6 = starvation: red dwell would exceed MAX_RED.
- Direction priority within a code: NS > SN > EW > WE.
- Dwell: counter resets to 1 when the sampled code changes, otherwise increments, saturating. The check uses the dwell before the change.
- phase_count: +1 on each legal yellow->red while ARMED. Several directions on one edge add their count. Modulo 256. Held in SYNC/FAULT.
- FAULT: outputs held; armed=0. ack=1 sampled -> SYNC, fault=0 and code/dir cleared next edge. A new violation during FAULT is ignored; the first fault is kept.
- CLEAR_N asserted in any state returns to full reset values immediately.

Test Plan:
- Reset, all red 1 cycle, then NS green 4, yellow 2, red; others red -> armed=1 one edge after reset release, no fault, phase_count=1.
- ARMED, NS=10 and EW=10 in the same cycle -> fault=1 next edge, fault_code=2, fault_dir=0.
- SN green 4 cycles then directly red -> fault_code=3, fault_dir=1. Also inject WE=11 together with an EW green->red -> fault_code=1, fault_dir=3.
- EW green 3 cycles then yellow -> fault_code=4, fault_dir=2. WE yellow 1 cycle then red -> fault_code=5, fault_dir=3.
- All red for 41 consecutive armed cycles -> fault_code=6, fault_dir=0. Pulse ack -> fault=0, state SYNC, re-arms on the next all-red sample.
- Run 256 legal phases -> phase_count wraps to 0. Assert CLEAR_N=0 mid-green -> all outputs zero immediately, then re-sync.
